pe_multicast_ctrl: RTL
======================

# pe_multicast_ctrl

Multicast load controller for a column of `pe` instances. It accepts a tagged stream of ifmap and filter words from the global buffer side. It delivers each word, registered, to every PE whose configured row ID matches the word's tag, and drives those PEs' `ifmap_enable`/`filter_enable` strobes. Upstream is back-pressured from the PEs' `ready` outputs, and `done` is signalled after a programmed number of transfers.

## Interface
Parameters:
- `BITWIDTH`, 16, data word width (matches `pe`)
- `NUM_PE`, 4, number of PEs driven
- `ID_WIDTH`, 4, width of row ID / tag
- `CNT_WIDTH`, 16, width of transfer counter

Ports:
- `clk` in 1: single clock, rising edge
- `rstb` in 1: reset, synchronous, active-low
- `cfg_we` in 1: write one ID table entry (honoured only in IDLE)
- `cfg_idx` in $clog2(NUM_PE): PE index to write
- `cfg_id` in ID_WIDTH: row ID for that PE
- `cfg_total` in CNT_WIDTH: transfers per run, sampled on `start`
- `start` in 1: begin a run (honoured only in IDLE)
- `in_valid` in 1: upstream word valid
- `in_ready` out 1: upstream word accepted when `in_valid && in_ready`
- `in_data` in BITWIDTH signed: word
- `in_is_filter` in 1: 1 = filter word, 0 = ifmap word
- `in_tag` in ID_WIDTH: destination row ID
- `pe_ready` in NUM_PE: `ready` of each PE
- `ifmap_bus` out BITWIDTH signed: broadcast ifmap to all PEs
- `filter_bus` out BITWIDTH signed: broadcast filter to all PEs
- `ifmap_enable` out NUM_PE: per-PE ifmap load strobe
- `filter_enable` out NUM_PE: per-PE filter load strobe
- `busy` out 1: high in RUN
- `done` out 1: one-cycle pulse at end of run

## Operation
- ID table: NUM_PE entries of ID_WIDTH. On reset, entry i = i. `cfg_we` in RUN/DONE is ignored.
- `match[i] = (id_table[i] == in_tag)`, combinational.
- `in_ready = (state==RUN) && ((match & ~pe_ready) == 0)`.
  - A word is accepted only when all matching PEs are ready.
  - A word matching no PE is accepted and dropped, and still counts as a transfer.
- FSM:
  - IDLE: `busy=0`. On `start`, latch `cfg_total`, clear `xfer_cnt` and go to RUN. If `cfg_total==0`, go straight to DONE.
  - RUN: `busy=1`. Each accepted word increments `xfer_cnt`. On the accept that makes `xfer_cnt+1 == total`, go to DONE. `start` is ignored.
  - DONE: `done=1` for one cycle, then IDLE. `in_ready=0`.
- Delivery on an accepted word, registered to the next cycle:
  - filter word: `filter_bus <= in_data`, `filter_enable <= match`, `ifmap_enable <= 0`; `ifmap_bus` holds its value.
  - ifmap word: symmetric.
  - Cycle without an accept: both enable vectors are 0; buses hold.
- Counter arithmetic is unsigned CNT_WIDTH, compared for equality only, and never wraps within a run.
- `cfg_we` and `start` in the same IDLE cycle: the table write takes effect, and the run uses the new table from its first cycle.

## Timing
- Reset (`rstb` low at a clock edge):
  - FSM goes to IDLE.
  - `in_ready`, `busy`, `done`, `ifmap_enable`, `filter_enable` = 0.
  - Buses = 0, `xfer_cnt` = 0, ID table = identity.
- Reset mid-run aborts the run with no `done`; any pending enable is cleared in the same edge.
- Accept-to-enable latency: 1 cycle. The enable is high for exactly one cycle per accepted word.
- Throughput: one word per cycle while matching PEs hold `ready=1`.
- `in_ready` depends combinationally on `pe_ready`, `in_tag` and state; there is no combinational path from `in_valid`.
- `done` asserts the cycle after the final accept. `busy` falls in the same cycle `done` rises.
- `pe_ready` dropping the cycle after an accept does not cancel the already-registered enable.

## Structure
- Shared package `pe_pkg`:
  - `BITWIDTH`, `RF_ADDR_WIDTH`
  - FSM state enum (IDLE, RUN, DONE)
  - PE state constants (LOAD, MAC, ACC, NEXT_ROW)
- One natural sub-module, `pe_id_table`: the ID register file with write port and NUM_PE parallel tag comparators producing `match`.
- FSM, counter and delivery registers live in the top level.

## Test plan
- Reset then identity table: `start`, `cfg_total=3`, filter words 5,6,7 tagged 2, all PEs ready.
  - `filter_enable` = 4'b0100 for 3 consecutive cycles, each one cycle after its accept.
  - `filter_bus` = 5,6,7.
  - `done` pulses once, one cycle after the third accept.
- Multicast: set IDs {1,1,0,1}, then send ifmap word -4 tagged 1.
  - `ifmap_enable` = 4'b1011, `ifmap_bus` = -4.
- Back-pressure: PE1 `ready=0` with a word tagged for PE1.
  - `in_ready=0` while stalled, with no enables.
  - Raising PE1 ready accepts the word, and the enable follows next cycle.
- Unmatched tag 9 with `cfg_total=1`: word accepted, no enables, `done` pulses.
- `cfg_total=0`: `start` goes to DONE with no accepts, `done` pulses 1 cycle later, `in_ready` never high.
- Reset asserted mid-run after 2 of 4 accepts:
  - Next cycle: enables 0, `busy` 0, no `done`.
  - A new run of 2 completes normally.

Source files
------------

// File: rtl/pe_pkg.sv
// ============================================================================
// Module      : pe_pkg
// Description : Shared types and constants for the PE array and its loaders.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_pkg;

    localparam int BITWIDTH      = 16;
    localparam int RF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Processing-element internal phases, shared so loaders and PEs agree.
    localparam logic [1:0] PE_LOAD     = 2'd0;
    localparam logic [1:0] PE_MAC      = 2'd1;
    localparam logic [1:0] PE_ACC      = 2'd2;
    localparam logic [1:0] PE_NEXT_ROW = 2'd3;

endpackage

`default_nettype wire

// File: rtl/pe_id_table.sv
// ============================================================================
// Module      : pe_id_table
// Description : Per-PE row-ID register file with parallel tag comparators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_id_table #(
    parameter int NUM_PE    = 4,
    parameter int ID_WIDTH  = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 we,
    input  logic [IDX_WIDTH-1:0] idx,
    input  logic [ID_WIDTH-1:0]  id,
    input  logic [ID_WIDTH-1:0]  tag,
    output logic [NUM_PE-1:0]    match
);

    import pe_pkg::*;

    logic [ID_WIDTH-1:0] r_id [NUM_PE];

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_entry
            // Entries reset to their own index so an unconfigured column maps tag i to PE i.
            always_ff @(posedge clk) begin
                if (!rstb) begin
                    r_id[gi] <= ID_WIDTH'(gi);
                end else if (we && (idx == IDX_WIDTH'(gi))) begin
                    r_id[gi] <= id;
                end
            end

            assign match[gi] = (r_id[gi] == tag);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/pe_multicast_ctrl.sv
// ============================================================================
// Module      : pe_multicast_ctrl
// Description : Tag-routed multicast loader driving ifmap/filter strobes of a PE column.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_multicast_ctrl #(
    parameter int BITWIDTH  = 16,
    parameter int NUM_PE    = 4,
    parameter int ID_WIDTH  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rstb,
    input  logic                        cfg_we,
    input  logic [$clog2(NUM_PE)-1:0]   cfg_idx,
    input  logic [ID_WIDTH-1:0]         cfg_id,
    input  logic [CNT_WIDTH-1:0]        cfg_total,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BITWIDTH-1:0]  in_data,
    input  logic                        in_is_filter,
    input  logic [ID_WIDTH-1:0]         in_tag,
    input  logic [NUM_PE-1:0]           pe_ready,
    output logic signed [BITWIDTH-1:0]  ifmap_bus,
    output logic signed [BITWIDTH-1:0]  filter_bus,
    output logic [NUM_PE-1:0]           ifmap_enable,
    output logic [NUM_PE-1:0]           filter_enable,
    output logic                        busy,
    output logic                        done
);

    import pe_pkg::*;

    localparam int IDX_WIDTH = $clog2(NUM_PE);

    mc_state_t              r_state;
    mc_state_t              w_state_next;
    logic [CNT_WIDTH-1:0]   r_total;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [NUM_PE-1:0]      w_match;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_cfg_we;

    assign w_cfg_we = cfg_we && (r_state == IDLE);

    pe_id_table #(
        .NUM_PE    (NUM_PE),
        .ID_WIDTH  (ID_WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_id_table (
        .clk   (clk),
        .rstb  (rstb),
        .we    (w_cfg_we),
        .idx   (cfg_idx),
        .id    (cfg_id),
        .tag   (in_tag),
        .match (w_match)
    );

    // A word waits until every PE it targets can take it; untargeted words pass straight through.
    assign in_ready = (r_state == RUN) && ((w_match & ~pe_ready) == '0);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt + CNT_WIDTH'(1)) == r_total;

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (cfg_total == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_accept && w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            r_total <= '0;
            r_cnt   <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_total <= cfg_total;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            ifmap_bus     <= '0;
            filter_bus    <= '0;
            ifmap_enable  <= '0;
            filter_enable <= '0;
        end else begin
            ifmap_enable  <= '0;
            filter_enable <= '0;
            if (w_accept) begin
                if (in_is_filter) begin
                    filter_bus    <= in_data;
                    filter_enable <= w_match;
                end else begin
                    ifmap_bus     <= in_data;
                    ifmap_enable  <= w_match;
                end
            end
        end
    end

endmodule

`default_nettype wire
